// File: rtl/sync_full_adder.sv
// sync_full_adder
//   Registered ripple-carry adder. {cout, sum} take a + b + cin on every rising
//   clk edge, so the outputs are glitch-free and aligned to clk. WIDTH=1 is the
//   plain single-bit full adder.
//
// Ports
//   clk   in   1      clock, all state updates on its rising edge
//   rst   in   1      synchronous active-high reset, clears sum and cout
//   a     in   WIDTH  addend A, unsigned
//   b     in   WIDTH  addend B, unsigned
//   cin   in   1      carry-in, feeds bit 0 of the ripple chain
//   sum   out  WIDTH  registered (a + b + cin) mod 2^WIDTH
//   cout  out  1      registered carry out of bit WIDTH-1
module sync_full_adder #(
    parameter int unsigned WIDTH = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    // carry[i] is the carry into bit i; carry[WIDTH] is the final carry-out.
    logic [WIDTH:0]   carry;
    logic [WIDTH-1:0] sum_d;
    logic             cout_d;

    logic [WIDTH-1:0] sum_q;
    logic             cout_q;

    // Ripple chain, bit 0 upward. Each stage is a textbook full adder.
    always_comb begin
        carry    = '0;
        sum_d    = '0;
        carry[0] = cin;
        for (int unsigned i = 0; i < WIDTH; i++) begin
            sum_d[i]     = a[i] ^ b[i] ^ carry[i];
            carry[i + 1] = (a[i] & b[i]) | (carry[i] & (a[i] ^ b[i]));
        end
        cout_d = carry[WIDTH];
    end

    // Output registers are the only state; reset wins over the add and
    // discards the operands sampled on that edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            sum_q  <= '0;
            cout_q <= 1'b0;
        end else begin
            sum_q  <= sum_d;
            cout_q <= cout_d;
        end
    end

    assign sum  = sum_q;
    assign cout = cout_q;

endmodule

// File: tb/tb_sync_full_adder.sv
// tb_sync_full_adder
//   Directed bench for sync_full_adder. Drives a WIDTH=1 and a WIDTH=4 instance
//   from one clock; inputs change on the falling edge and outputs are sampled
//   1 time unit after the rising edge.
module tb_sync_full_adder;

    logic       clk;
    logic       rst;
    logic       a1, b1, cin1;
    logic       sum1, cout1;
    logic [3:0] a4, b4;
    logic       cin4;
    logic [3:0] sum4;
    logic       cout4;

    int n_checks;
    int n_pass;

    sync_full_adder #(.WIDTH(1)) u_dut1 (
        .clk  (clk),
        .rst  (rst),
        .a    (a1),
        .b    (b1),
        .cin  (cin1),
        .sum  (sum1),
        .cout (cout1)
    );

    sync_full_adder #(.WIDTH(4)) u_dut4 (
        .clk  (clk),
        .rst  (rst),
        .a    (a4),
        .b    (b4),
        .cin  (cin4),
        .sum  (sum4),
        .cout (cout4)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Values are compared as {cout, sum} zero-extended to 5 bits.
    task automatic check(input string tag, input logic [4:0] got, input logic [4:0] exp);
        n_checks++;
        if (got !== exp) begin
            $display("FAIL %s: got {cout,sum}=%b, expected %b", tag, got, exp);
        end else begin
            n_pass++;
        end
    endtask

    function automatic logic [4:0] obs1();
        return {3'b000, cout1, sum1};
    endfunction

    function automatic logic [4:0] obs4();
        return {cout4, sum4};
    endfunction

    task automatic edge_sample();
        @(posedge clk);
        #1;
    endtask

    // Hand-computed WIDTH=1 truth table indexed by {a, b, cin}: {cout, sum}.
    logic [1:0] tt_exp [8] = '{2'b00, 2'b01, 2'b01, 2'b10, 2'b01, 2'b10, 2'b10, 2'b11};

    // WIDTH=4 boundary vectors {a, b, cin} with hand-computed {cout, sum}.
    logic [8:0] bnd_vec [3] = '{{4'hF, 4'hF, 1'b1}, {4'hF, 4'h0, 1'b1}, {4'h5, 4'hA, 1'b0}};
    logic [4:0] bnd_exp [3] = '{5'h1F, 5'h10, 5'h0F};

    initial begin
        logic [2:0] v;
        logic [3:0] ta, tb;
        logic       tc;
        logic [4:0] ref_sum;

        n_checks = 0;
        n_pass   = 0;

        // Reset held for two edges with all-ones operands.
        rst  = 1'b1;
        a1   = 1'b1; b1 = 1'b1; cin1 = 1'b1;
        a4   = 4'hF; b4 = 4'hF; cin4 = 1'b1;
        for (int i = 0; i < 2; i++) begin
            edge_sample();
            check($sformatf("reset1_edge%0d", i), obs1(), 5'b00000);
            check($sformatf("reset4_edge%0d", i), obs4(), 5'b00000);
        end
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        check("post_reset1", obs1(), 5'b00011);
        check("post_reset4", obs4(), 5'h1F);

        // Exhaustive single-bit truth table.
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            v = 3'(i);
            {a1, b1, cin1} = v;
            edge_sample();
            check($sformatf("tt_%b", v), obs1(), {3'b000, tt_exp[i]});
        end

        // Outputs hold between edges even when the inputs move.
        @(negedge clk);
        {a1, b1, cin1} = 3'b100;
        edge_sample();
        check("hold_first", obs1(), 5'b00001);
        #2;
        {a1, b1, cin1} = 3'b110;
        #1;
        check("hold_after_change", obs1(), 5'b00001);
        @(negedge clk);
        check("hold_negedge", obs1(), 5'b00001);
        edge_sample();
        check("hold_next_edge", obs1(), 5'b00010);

        // Reset mid-stream discards the operands sampled on that edge.
        @(negedge clk);
        {a1, b1, cin1} = 3'b111;
        edge_sample();
        check("mid_pre", obs1(), 5'b00011);
        @(negedge clk);
        rst = 1'b1;
        edge_sample();
        check("mid_reset1", obs1(), 5'b00000);
        check("mid_reset4", obs4(), 5'b00000);
        @(negedge clk);
        rst = 1'b0;
        edge_sample();
        check("mid_release", obs1(), 5'b00011);

        // WIDTH=4 boundaries.
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            {a4, b4, cin4} = bnd_vec[i];
            edge_sample();
            check($sformatf("w4_bnd%0d", i), obs4(), bnd_exp[i]);
        end

        // Back-to-back: a fresh vector every cycle, consecutive results differ.
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            ta = 4'((i * 7 + 3) % 16);
            tb = 4'((i * 5 + 9) % 16);
            tc = 1'(i % 2);
            {a4, b4, cin4} = {ta, tb, tc};
            ref_sum = 5'(ta) + 5'(tb) + 5'(tc);
            edge_sample();
            check($sformatf("b2b_%0d", i), obs4(), ref_sum);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
